// File: rtl/ntt_job_sched_pkg.sv
// Shared definitions for the NTT/INTT job scheduler: FSM state encoding,
// datapath mode values and the selected-CU done helper.
package ntt_job_sched_pkg;

  // One-hot scheduler states.
  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StStart  = 5'b00010,
    StWaitLo = 5'b00100,
    StWaitHi = 5'b01000,
    StCmpl   = 5'b10000
  } sched_state_e;

  // Datapath mux select / job type encoding.
  localparam logic ModeNtt  = 1'b0;
  localparam logic ModeIntt = 1'b1;

  // Done level of the control unit that owns the current job.
  function automatic logic sel_done(input logic mode, input logic ntt_done,
                                    input logic intt_done);
    return (mode == ModeIntt) ? intt_done : ntt_done;
  endfunction

endpackage

// File: rtl/ntt_rr_arb2.sv
// Two-way round-robin arbiter between the NTT and INTT requesters.
// rr_last remembers the side granted most recently; on a tie the other side wins.
module ntt_rr_arb2
  import ntt_job_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_ntt_i,
  input  logic req_intt_i,
  input  logic upd_i,       // a grant was taken this cycle
  output logic gnt_ntt_o,
  output logic gnt_intt_o
);

  logic rr_last_q, rr_last_d;

  // Grant: single requester wins outright, a tie goes to the side not served last.
  always_comb begin
    gnt_ntt_o  = req_ntt_i & (~req_intt_i | (rr_last_q == ModeIntt));
    gnt_intt_o = req_intt_i & ~gnt_ntt_o;
    rr_last_d  = rr_last_q;
    if (upd_i) begin
      rr_last_d = gnt_intt_o ? ModeIntt : ModeNtt;
    end
  end

  // Last-served register; starts at INTT so NTT wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= ModeIntt;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/ntt_job_sched.sv
// Job scheduler in front of the shared ntt_cu/intt_cu pair. Accepts one job at a
// time from the NTT and INTT requesters, launches it, waits for the CU done level
// to fall and rise again, then returns a tagged completion.
// Optional watchdog: define NTT_SCHED_WDOG_EN to abort hung jobs with cmp_err=1.
module ntt_job_sched
  import ntt_job_sched_pkg::*;
#(
  parameter int unsigned ID_W     = 4,
  parameter int unsigned BANK_W   = 2,
  parameter int unsigned WDOG_CYC = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ntt_req_valid,
  output logic              ntt_req_ready,
  input  logic [ID_W-1:0]   ntt_req_id,
  input  logic [BANK_W-1:0] ntt_req_bank,
  input  logic              intt_req_valid,
  output logic              intt_req_ready,
  input  logic [ID_W-1:0]   intt_req_id,
  input  logic [BANK_W-1:0] intt_req_bank,
  output logic              cu_ntt_start,
  output logic              cu_intt_start,
  output logic              cu_mode,
  output logic [BANK_W-1:0] cu_bank,
  input  logic              cu_ntt_done,
  input  logic              cu_intt_done,
  output logic              cmp_valid,
  input  logic              cmp_ready,
  output logic [ID_W-1:0]   cmp_id,
  output logic              cmp_is_intt,
  output logic              cmp_err,
  output logic              sched_busy
);

  sched_state_e state_q, state_d;

  logic              mode_q, mode_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  logic gnt_ntt, gnt_intt;
  logic idle, hs, done_sel, wdog_hit;

  assign idle     = (state_q == StIdle);
  assign hs       = idle & (gnt_ntt | gnt_intt);
  assign done_sel = sel_done(mode_q, cu_ntt_done, cu_intt_done);

  ntt_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_ntt_i  (ntt_req_valid),
    .req_intt_i (intt_req_valid),
    .upd_i      (hs),
    .gnt_ntt_o  (gnt_ntt),
    .gnt_intt_o (gnt_intt)
  );

`ifdef NTT_SCHED_WDOG_EN
  localparam int unsigned CntW = $clog2(WDOG_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            in_wait;

  assign in_wait  = (state_q == StWaitLo) | (state_q == StWaitHi);
  assign wdog_hit = in_wait & (cnt_q == CntW'(WDOG_CYC - 1));

  // Watchdog counter: cleared at launch, runs while waiting on the CU.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StStart) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (wdog_hit) begin
      err_d = 1'b1;
    end else if (in_wait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cmp_err = (state_q == StCmpl) & err_q;
`else
  assign wdog_hit = 1'b0;
  assign cmp_err  = 1'b0;
`endif

  // Next-state and job latch logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    id_d    = id_q;
    bank_d  = bank_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          state_d = StStart;
          mode_d  = gnt_intt ? ModeIntt : ModeNtt;
          id_d    = gnt_intt ? intt_req_id : ntt_req_id;
          bank_d  = gnt_intt ? intt_req_bank : ntt_req_bank;
        end
      end
      StStart: state_d = StWaitLo;
      StWaitLo: begin
        // Done is high while the CU is idle; its fall proves the CU took the job.
        if (wdog_hit) begin
          state_d = StCmpl;
        end else if (!done_sel) begin
          state_d = StWaitHi;
        end
      end
      StWaitHi: begin
        if (wdog_hit || done_sel) begin
          state_d = StCmpl;
        end
      end
      StCmpl: begin
        if (cmp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and job registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeNtt;
      id_q    <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      bank_q  <= bank_d;
    end
  end

  // Outputs decoded from registered state only, except the IDLE ready grant.
  always_comb begin
    ntt_req_ready  = idle & gnt_ntt;
    intt_req_ready = idle & gnt_intt;
    cu_ntt_start   = (state_q == StStart) & (mode_q == ModeNtt);
    cu_intt_start  = (state_q == StStart) & (mode_q == ModeIntt);
    cu_mode        = mode_q;
    cu_bank        = bank_q;
    cmp_valid      = (state_q == StCmpl);
    cmp_id         = id_q;
    cmp_is_intt    = mode_q;
    sched_busy     = ~idle;
  end

endmodule

// File: tb/tb_ntt_job_sched.sv
// Directed self-checking bench for ntt_job_sched with a simple CU done-level model.
module tb_ntt_job_sched;

  localparam int unsigned WDOG = 8192;

  logic       clk;
  logic       rst_n;
  logic       ntt_req_valid, ntt_req_ready;
  logic [3:0] ntt_req_id;
  logic [1:0] ntt_req_bank;
  logic       intt_req_valid, intt_req_ready;
  logic [3:0] intt_req_id;
  logic [1:0] intt_req_bank;
  logic       cu_ntt_start, cu_intt_start, cu_mode;
  logic [1:0] cu_bank;
  logic       cu_ntt_done, cu_intt_done;
  logic       cmp_valid, cmp_ready;
  logic [3:0] cmp_id;
  logic       cmp_is_intt, cmp_err, sched_busy;

  int n_checks = 0;
  int n_errors = 0;
  int ntt_starts = 0;
  int intt_starts = 0;

  // CU model knobs: cycles done stays high after start, cycles it stays low.
  int  ntt_hold = 0, ntt_busy = 10, intt_hold = 0, intt_busy = 10;
  bit  ntt_never = 0;

  ntt_job_sched #(
    .ID_W     (4),
    .BANK_W   (2),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ntt_req_valid  (ntt_req_valid),
    .ntt_req_ready  (ntt_req_ready),
    .ntt_req_id     (ntt_req_id),
    .ntt_req_bank   (ntt_req_bank),
    .intt_req_valid (intt_req_valid),
    .intt_req_ready (intt_req_ready),
    .intt_req_id    (intt_req_id),
    .intt_req_bank  (intt_req_bank),
    .cu_ntt_start   (cu_ntt_start),
    .cu_intt_start  (cu_intt_start),
    .cu_mode        (cu_mode),
    .cu_bank        (cu_bank),
    .cu_ntt_done    (cu_ntt_done),
    .cu_intt_done   (cu_intt_done),
    .cmp_valid      (cmp_valid),
    .cmp_ready      (cmp_ready),
    .cmp_id         (cmp_id),
    .cmp_is_intt    (cmp_is_intt),
    .cmp_err        (cmp_err),
    .sched_busy     (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse counters, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (cu_ntt_start) ntt_starts++;
    if (cu_intt_start) intt_starts++;
  end

  // NTT CU model.
  initial begin
    cu_ntt_done = 1'b1;
    forever begin
      step();
      if (cu_ntt_start && !ntt_never) begin
        repeat (ntt_hold) step();
        cu_ntt_done = 1'b0;
        repeat (ntt_busy) step();
        cu_ntt_done = 1'b1;
      end
    end
  end

  // INTT CU model.
  initial begin
    cu_intt_done = 1'b1;
    forever begin
      step();
      if (cu_intt_start) begin
        repeat (intt_hold) step();
        cu_intt_done = 1'b0;
        repeat (intt_busy) step();
        cu_intt_done = 1'b1;
      end
    end
  end

  task automatic wait_cmp(input int bound, output int cyc);
    cyc = 0;
    while (!cmp_valid && cyc < bound) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ntt_req_valid = 1'b0;
    intt_req_valid = 1'b0;
    cmp_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Runs one job whose request is already valid; checks grant, launch and completion.
  task automatic run_job(input string tag, input bit is_intt, input logic [3:0] id,
                         input logic [1:0] bank, input int exp_lat, input bit exp_err);
    int lat;
    int ns, is;
    #1;
    chk({tag, "_ntt_ready"}, ntt_req_ready, !is_intt);
    chk({tag, "_intt_ready"}, intt_req_ready, is_intt);
    ns = ntt_starts;
    is = intt_starts;
    step();
    chk({tag, "_ntt_start"}, cu_ntt_start, !is_intt);
    chk({tag, "_intt_start"}, cu_intt_start, is_intt);
    chk({tag, "_mode"}, cu_mode, is_intt);
    chk({tag, "_bank"}, cu_bank, bank);
    chk({tag, "_busy"}, sched_busy, 1);
    wait_cmp(exp_lat + 200, lat);
    chk({tag, "_cmp_valid"}, cmp_valid, 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_cmp_id"}, cmp_id, id);
    chk({tag, "_is_intt"}, cmp_is_intt, is_intt);
    chk({tag, "_err"}, cmp_err, exp_err);
    chk({tag, "_ready_blocked"}, {ntt_req_ready, intt_req_ready}, 0);
    chk({tag, "_ntt_pulses"}, ntt_starts - ns, !is_intt);
    chk({tag, "_intt_pulses"}, intt_starts - is, is_intt);
    cmp_ready = 1'b1;
    step();
    cmp_ready = 1'b0;
    chk({tag, "_cmp_drop"}, cmp_valid, 0);
  endtask

  initial begin
    ntt_req_id = '0;
    ntt_req_bank = '0;
    intt_req_id = '0;
    intt_req_bank = '0;
    do_reset();

    // Reset state (checked while still in reset).
    rst_n = 1'b0;
    #1;
    chk("rst_busy", sched_busy, 0);
    chk("rst_readies", {ntt_req_ready, intt_req_ready}, 0);
    chk("rst_starts", {cu_ntt_start, cu_intt_start}, 0);
    chk("rst_mode_bank", {cu_mode, cu_bank}, 0);
    chk("rst_cmp", {cmp_valid, cmp_id, cmp_is_intt, cmp_err}, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: single NTT job, long CU run.
    ntt_busy = 6156;
    ntt_req_id = 4'd3;
    ntt_req_bank = 2'd1;
    ntt_req_valid = 1'b1;
    #1;
    chk("t1_idle_busy", sched_busy, 0);
    run_job("t1", 1'b0, 4'd3, 2'd1, 6157, 1'b0);
    ntt_req_valid = 1'b0;
    ntt_busy = 10;
    chk("t1_back_idle", sched_busy, 0);

    // 2: both valid after reset: N, I, N, I.
    do_reset();
    ntt_req_id = 4'd5;
    ntt_req_bank = 2'd2;
    intt_req_id = 4'd9;
    intt_req_bank = 2'd3;
    ntt_req_valid = 1'b1;
    intt_req_valid = 1'b1;
    run_job("t2a", 1'b0, 4'd5, 2'd2, 11, 1'b0);
    run_job("t2b", 1'b1, 4'd9, 2'd3, 11, 1'b0);
    run_job("t2c", 1'b0, 4'd5, 2'd2, 11, 1'b0);
    run_job("t2d", 1'b1, 4'd9, 2'd3, 11, 1'b0);
    ntt_req_valid = 1'b0;
    intt_req_valid = 1'b0;

    // 3: completion back-pressure for 20 cycles.
    begin
      int lat;
      ntt_req_id = 4'd6;
      ntt_req_bank = 2'd0;
      ntt_req_valid = 1'b1;
      step();
      ntt_req_valid = 1'b0;
      ntt_req_id = 4'd15;
      intt_req_valid = 1'b1;
      wait_cmp(200, lat);
      chk("t3_cmp_valid", cmp_valid, 1);
      for (int i = 0; i < 20; i++) begin
        chk("t3_hold_valid", cmp_valid, 1);
        chk("t3_hold_id", cmp_id, 4'd6);
        chk("t3_hold_type", cmp_is_intt, 0);
        chk("t3_hold_ready", {ntt_req_ready, intt_req_ready}, 0);
        step();
      end
      cmp_ready = 1'b1;
      #1;
      chk("t3_hs_no_overlap", intt_req_ready, 0);
      step();
      cmp_ready = 1'b0;
      chk("t3_after_hs_valid", cmp_valid, 0);
      chk("t3_after_hs_ready", intt_req_ready, 1);
      intt_req_valid = 1'b0;
      step();
    end

    // 4: done stays high 3 cycles after start.
    intt_hold = 3;
    intt_busy = 5;
    intt_req_id = 4'd10;
    intt_req_bank = 2'd1;
    intt_req_valid = 1'b1;
    run_job("t4", 1'b1, 4'd10, 2'd1, 9, 1'b0);
    intt_req_valid = 1'b0;
    intt_hold = 0;

    // 5: reset mid-job (WAIT_HI), then a fresh job.
    intt_busy = 50;
    intt_req_id = 4'd7;
    intt_req_bank = 2'd2;
    intt_req_valid = 1'b1;
    step();
    intt_req_valid = 1'b0;
    chk("t5_mode", cu_mode, 1);
    chk("t5_bank", cu_bank, 2'd2);
    repeat (10) step();
    chk("t5_busy_mid", sched_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", sched_busy, 0);
    chk("t5_rst_mode_bank", {cu_mode, cu_bank}, 0);
    chk("t5_rst_cmp", {cmp_valid, cmp_id, cmp_is_intt, cmp_err}, 0);
    chk("t5_rst_starts", {cu_ntt_start, cu_intt_start}, 0);
    step();
    rst_n = 1'b1;
    ntt_req_id = 4'd12;
    ntt_req_bank = 2'd3;
    ntt_req_valid = 1'b1;
    run_job("t5", 1'b0, 4'd12, 2'd3, 11, 1'b0);
    ntt_req_valid = 1'b0;
    repeat (50) step();
    chk("t5_no_stale_cmp", cmp_valid, 0);
    intt_busy = 10;

`ifdef NTT_SCHED_WDOG_EN
    // 6: CU never responds; watchdog forces an error completion.
    ntt_never = 1'b1;
    ntt_req_id = 4'd1;
    ntt_req_bank = 2'd0;
    ntt_req_valid = 1'b1;
    run_job("t6", 1'b0, 4'd1, 2'd0, WDOG + 1, 1'b1);
    ntt_req_valid = 1'b0;
    ntt_never = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
